aes_key_expand_multi: RTL and testbench
=======================================

// Module: aes_key_expand_multi
// PURPOSE
//  Iterative AES key schedule for AES-128/192/256, selected per run by key_len.
//  Expands the cipher key word by word and streams round keys rk0..rkNr, each
//  128 bits, over a valid/ready interface to the round datapath.
//  Throughput is set by WORDS_PER_CYCLE. The output stalls under back-pressure.
// PARAMETERS
//  WORDS_PER_CYCLE  1  schedule words produced per cycle; legal values 1, 2, 4
// PORTS
//  clk        in   1    clock
//  reset      in   1    synchronous, active-high reset
//  start      in   1    begin expansion; sampled only in IDLE
//  key_len    in   2    0=AES-128 (Nk=4,Nr=10), 1=AES-192 (6,12), 2=AES-256 (8,14), 3=illegal
//  key        in   256  cipher key; w0=key[255:224]; AES-128 uses [255:128], AES-192 uses [255:64]
//  busy       out  1    high from the cycle after start is accepted until done
//  rk_valid   out  1    rk_data is valid
//  rk_ready   in   1    consumer accepts; transfer occurs when rk_valid & rk_ready
//  rk_data    out  128  round key {w[4r],w[4r+1],w[4r+2],w[4r+3]}
//  rk_index   out  4    round number r of rk_data
//  rk_last    out  1    high with rk_data when r==Nr
//  done       out  1    1-cycle pulse, the cycle after the rk_last transfer
//  key_err    out  1    1-cycle pulse when start is accepted with key_len==3
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; internal registers cleared.
//  Reset mid-run aborts immediately. No further rk_valid until the next start.
//  FSM states and transitions:
//   IDLE -> RUN   on start with key_len!=3. key and key_len are latched.
//   IDLE stays in IDLE on start with key_len==3, and key_err pulses.
//   RUN -> DRAIN  when the final word w[4Nr+3] is generated.
//   DRAIN -> DONE on the rk_last handshake.
//   DONE -> IDLE  after 1 cycle, with done=1 during that cycle.
//  start in any state other than IDLE is ignored. key and key_len changes while busy are ignored.
//  Word generation (FIPS-197), with word counter i starting at 0:
//   i<Nk: w[i] = latched key word i.
//   Otherwise t = w[i-1]:
//    i mod Nk==0: t = SubWord(RotWord(t)) ^ {rcon,24'h0}
//    Nk==8 and i mod 8==4: t = SubWord(t)
//   Then w[i] = w[i-Nk] ^ t.
//  Implementation rules:
//   i mod Nk comes from a wrap counter; no divider.
//   rcon starts at 8'h01. After each use it is updated by xtime: {r[6:0],1'b0} ^ (r[7]?8'h1b:0).
//   The last Nk words are held in an 8-word sliding window.
//   WORDS_PER_CYCLE generator stages are chained combinationally within one cycle.
//  Generated words fill a 4-word assembly buffer. Total words are 44, 52 or 60, all multiples of 4.
//  Assembly never straddles round keys.
//  When the buffer completes, it loads into the output register:
//   rk_data, rk_index and rk_last, with rk_valid set the next cycle.
//  Generation advances in a cycle only when !(rk_valid & !rk_ready).
//  Output fields stay stable while rk_valid & !rk_ready.
//  Latency: rk0 valid 1+4/WORDS_PER_CYCLE cycles after the start-accept edge.
//  With rk_ready held high, one round key every 4/WORDS_PER_CYCLE cycles.
//   WPC=4 gives 1 round key per cycle.
//  Simultaneous rk_valid&rk_ready and assembly completion: the new key loads in the same edge.
//   No bubble.
// TESTING
//  AES-128, WPC=1, key 2b7e151628aed2a6abf7158809cf4f3c, ready=1:
//   rk1=a0fafe1788542cb123a339392a6c7605, rk10=d014f9a8c9ee2589e13f0cc8b6630ca6.
//   11 transfers total; rk_last only on rk10; done pulse 1 cycle later.
//  AES-192, WPC=2, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
//   rk12=e98ba06f448c773c8ecc720401002202; 13 transfers.
//  AES-256, WPC=4, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
//   rk14=fe4890d1e6188d0b046df344706c631e.
//   rk_valid high on 15 consecutive cycles with ready=1.
//  Back-pressure: random rk_ready with ~30% duty.
//   rk_data/rk_index are held while stalled; sequence identical to the ready=1 run; no drops or duplicates.
//  key_len=3 start: key_err pulse, busy stays 0, no rk_valid.
//   start pulses during a run are ignored; output matches the uninterrupted run.
//  reset asserted after rk3 of AES-128: all outputs 0 next cycle.
//   A new AES-256 start then yields correct rk0..rk14.

Source files
------------

// File: rtl/aes_key_expand_multi.sv
// Iterative AES-128/192/256 key schedule streaming 128-bit round keys over valid/ready.
// WORDS_PER_CYCLE chained word generators feed a 4-word assembly buffer ahead of the output register.
module aes_key_expand_multi #(
    parameter int WORDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_start,
    input  logic [1:0]   i_key_len,
    input  logic [255:0] i_key,
    output logic         o_busy,
    output logic         o_rk_valid,
    input  logic         i_rk_ready,
    output logic [127:0] o_rk_data,
    output logic [3:0]   o_rk_index,
    output logic         o_rk_last,
    output logic         o_done,
    output logic         o_key_err
);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sb(input logic [7:0] x);
        return SBOX[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] key_word(input logic [255:0] k, input logic [2:0] n);
        return k[255 - 32*int'(n) -: 32];
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t              r_state, w_next;
    logic [255:0]        r_key;
    logic [3:0]          r_nk, r_nr;
    logic [7:0][31:0]    r_win;        // r_win[j] = w[i-1-j]
    logic [5:0]          r_i;
    logic [2:0]          r_mod;        // i mod Nk
    logic [7:0]          r_rcon;
    logic [3:0][31:0]    r_asm;
    logic                r_asm_full;
    logic [3:0]          r_asm_idx;
    logic                r_key_err;

    logic                w_accept, w_adv, w_gen_last, w_asm_done;
    logic [7:0][31:0]    w_win;
    logic [5:0]          w_i, w_total;
    logic [2:0]          w_mod;
    logic [7:0]          w_rcon;
    logic [3:0][31:0]    w_asm;
    logic [31:0]         w_word, w_t;

    assign w_accept  = (r_state == S_IDLE) && i_start && (i_key_len != 2'd3);
    assign w_adv     = !(o_rk_valid && !i_rk_ready);
    assign w_total   = {r_nr + 4'd1, 2'b00};
    assign o_busy    = (r_state != S_IDLE);
    assign o_done    = (r_state == S_DONE);
    assign o_key_err = r_key_err;

    // Generator stages chained within one cycle; words never straddle a round key
    // because the word count per cycle divides 4.
    always_comb begin
        w_win      = r_win;
        w_i        = r_i;
        w_mod      = r_mod;
        w_rcon     = r_rcon;
        w_asm      = r_asm;
        w_asm_done = 1'b0;
        w_gen_last = 1'b0;
        w_word     = '0;
        w_t        = '0;
        for (int s = 0; s < WORDS_PER_CYCLE; s++) begin
            if (w_i < {2'b00, r_nk}) begin
                w_word = key_word(r_key, w_i[2:0]);
            end else begin
                w_t = w_win[0];
                if (w_mod == 3'd0) begin
                    w_t    = sub_word({w_t[23:0], w_t[31:24]}) ^ {w_rcon, 24'h0};
                    w_rcon = xtime(w_rcon);
                end else if (r_nk == 4'd8 && w_mod == 3'd4) begin
                    w_t = sub_word(w_t);
                end
                w_word = w_win[r_nk[2:0] - 3'd1] ^ w_t;
            end
            w_asm[w_i[1:0]] = w_word;
            if (w_i[1:0] == 2'd3)          w_asm_done = 1'b1;
            if (w_i == w_total - 6'd1)     w_gen_last = 1'b1;
            w_win = {w_win[6:0], w_word};
            w_mod = (w_mod == r_nk[2:0] - 3'd1) ? 3'd0 : w_mod + 3'd1;
            w_i   = w_i + 6'd1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_RUN;
            S_RUN:   if (w_adv && w_gen_last) w_next = S_DRAIN;
            S_DRAIN: if (o_rk_valid && i_rk_ready && o_rk_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_key      <= '0;
            r_nk       <= '0;
            r_nr       <= '0;
            r_win      <= '0;
            r_i        <= '0;
            r_mod      <= '0;
            r_rcon     <= '0;
            r_asm      <= '0;
            r_asm_full <= 1'b0;
            r_asm_idx  <= '0;
            r_key_err  <= 1'b0;
            o_rk_valid <= 1'b0;
            o_rk_data  <= '0;
            o_rk_index <= '0;
            o_rk_last  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_key_err <= (r_state == S_IDLE) && i_start && (i_key_len == 2'd3);
            // Output reload and generation share one enable, so a stalled key holds everything upstream.
            if (w_adv) begin
                if (r_asm_full) begin
                    o_rk_valid <= 1'b1;
                    o_rk_data  <= {r_asm[0], r_asm[1], r_asm[2], r_asm[3]};
                    o_rk_index <= r_asm_idx;
                    o_rk_last  <= (r_asm_idx == r_nr);
                end else begin
                    o_rk_valid <= 1'b0;
                end
                if (r_state == S_RUN) begin
                    r_win      <= w_win;
                    r_i        <= w_i;
                    r_mod      <= w_mod;
                    r_rcon     <= w_rcon;
                    r_asm      <= w_asm;
                    r_asm_full <= w_asm_done;
                    r_asm_idx  <= r_i[5:2];
                end else begin
                    r_asm_full <= 1'b0;
                end
            end
            if (w_accept) begin
                r_key      <= i_key;
                r_win      <= '0;
                r_i        <= '0;
                r_mod      <= '0;
                r_rcon     <= 8'h01;
                r_asm      <= '0;
                r_asm_full <= 1'b0;
                case (i_key_len)
                    2'd0:    begin r_nk <= 4'd4; r_nr <= 4'd10; end
                    2'd1:    begin r_nk <= 4'd6; r_nr <= 4'd12; end
                    default: begin r_nk <= 4'd8; r_nr <= 4'd14; end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aes_key_expand_multi.sv
// Bench for aes_key_expand_multi: three instances (1, 2 and 4 words per cycle) driven in parallel
// and compared against a FIPS-197 key expansion computed from GF(2^8) arithmetic.
module tb_aes_key_expand_multi;
    localparam int NG = 3;
    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic clk = 1'b0;
    logic reset, start, rk_ready;
    logic [1:0] key_len;
    logic [255:0] key;
    logic [NG-1:0] busy, rk_valid, rk_last, done, key_err;
    logic [NG-1:0][127:0] rk_data;
    logic [NG-1:0][3:0] rk_index;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NG; gi++) begin : g_dut
        aes_key_expand_multi #(.WORDS_PER_CYCLE(1 << gi)) u_dut (
            .clk(clk), .reset(reset), .i_start(start), .i_key_len(key_len), .i_key(key),
            .o_busy(busy[gi]), .o_rk_valid(rk_valid[gi]), .i_rk_ready(rk_ready),
            .o_rk_data(rk_data[gi]), .o_rk_index(rk_index[gi]), .o_rk_last(rk_last[gi]),
            .o_done(done[gi]), .o_key_err(key_err[gi]));
    end

    int checks = 0, errors = 0, cyc = 0;

    logic [7:0]   sbox [0:255];
    logic [31:0]  mw   [0:59];
    logic [127:0] cap_d [NG][16];
    logic [3:0]   cap_i [NG][16];
    logic         cap_l [NG][16];
    int cap_n[NG], vcnt[NG], first_v[NG], last_x[NG], done_n[NG], done_c[NG];
    bit           prev_stall [NG];
    logic [127:0] prev_d [NG];
    logic [3:0]   prev_i [NG];

    task automatic chk(input string tag, input int g, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s wpc=%0d observed %h expected %h", tag, 1 << g, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00, s;
            logic [15:0] d;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ 8'h63;
            for (int k = 1; k <= 4; k++) begin
                d = {inv, inv} << k;
                s = s ^ d[15:8];
            end
            sbox[x] = s;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    task automatic model(input int nk, input logic [255:0] k);
        for (int i = 0; i < 4 * (nk + 7); i++) begin
            logic [31:0] t;
            logic [7:0] rc = 8'h01;
            if (i < nk) begin
                mw[i] = k[255 - 32*i -: 32];
            end else begin
                t = mw[i-1];
                if (i % nk == 0) begin
                    for (int j = 1; j < i / nk; j++) rc = gmul(rc, 8'h02);
                    t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                end else if (nk == 8 && i % 8 == 4) begin
                    t = subw(t);
                end
                mw[i] = mw[i-nk] ^ t;
            end
        end
    endtask

    function automatic logic [127:0] rk_of(input int r);
        return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
    endfunction

    // One clock: observe all instances on the falling edge, then return 1 time unit after the rising edge.
    task automatic tick();
        @(negedge clk);
        for (int g = 0; g < NG; g++) begin
            if (reset) begin
                prev_stall[g] = 0;
            end else begin
                if (prev_stall[g]) begin
                    chk("hold_valid", g, rk_valid[g], 1);
                    chk("hold_data", g, rk_data[g], prev_d[g]);
                    chk("hold_index", g, rk_index[g], prev_i[g]);
                end
                if (rk_valid[g]) begin
                    vcnt[g]++;
                    if (first_v[g] < 0) first_v[g] = cyc;
                    if (rk_ready) begin
                        if (cap_n[g] < 16) begin
                            cap_d[g][cap_n[g]] = rk_data[g];
                            cap_i[g][cap_n[g]] = rk_index[g];
                            cap_l[g][cap_n[g]] = rk_last[g];
                        end
                        cap_n[g]++;
                        if (rk_last[g]) last_x[g] = cyc;
                    end
                end
                if (done[g]) begin
                    done_n[g]++;
                    done_c[g] = cyc;
                end
                prev_stall[g] = rk_valid[g] && !rk_ready;
                prev_d[g] = rk_data[g];
                prev_i[g] = rk_index[g];
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic clear_mon();
        for (int g = 0; g < NG; g++) begin
            cap_n[g] = 0; vcnt[g] = 0; first_v[g] = -1;
            last_x[g] = -1; done_n[g] = 0; done_c[g] = -1;
        end
    endtask

    task automatic run_case(input int klen, input logic [255:0] k, input bit rnd, input bit noise);
        int nk = 4 + 2 * klen, nr = 10 + 2 * klen, acc, n = 0;
        model(nk, k);
        clear_mon();
        key_len = 2'(klen);
        key = k;
        rk_ready = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
        start = 1;
        tick();
        acc = cyc;
        start = 0;
        while (!(done_n[0] > 0 && done_n[1] > 0 && done_n[2] > 0) && n < 4000) begin
            if (rnd) rk_ready = ($urandom_range(0, 9) < 3);
            if (noise) begin
                start   = (&busy) && ($urandom_range(0, 7) == 0);
                key     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                key_len = 2'($urandom_range(0, 3));
            end
            tick();
            n++;
        end
        start = 0;
        rk_ready = 1;
        for (int g = 0; g < NG; g++) begin
            chk("done_count", g, done_n[g], 1);
            chk("xfer_count", g, cap_n[g], nr + 1);
            for (int j = 0; j < cap_n[g] && j < 16; j++) begin
                chk($sformatf("rk%0d_data", j), g, cap_d[g][j], rk_of(j));
                chk($sformatf("rk%0d_index", j), g, cap_i[g][j], j);
                chk($sformatf("rk%0d_last", j), g, cap_l[g][j], j == nr);
            end
            chk("done_after_last", g, done_c[g], last_x[g] + 1);
            chk("first_latency", g, first_v[g], acc + 1 + (4 >> g));
            if (!rnd) begin
                chk("valid_cycles", g, vcnt[g], nr + 1);
                chk("stream_span", g, last_x[g] - first_v[g], nr * (4 >> g));
            end
        end
        tick();
    endtask

    initial begin
        int n;
        build_sbox();
        reset = 1; start = 0; rk_ready = 1; key_len = 0; key = '0;
        clear_mon();
        repeat (3) tick();
        for (int g = 0; g < NG; g++) begin
            chk("rst_valid", g, rk_valid[g], 0);
            chk("rst_busy", g, busy[g], 0);
            chk("rst_done", g, done[g], 0);
            chk("rst_key_err", g, key_err[g], 0);
            chk("rst_data", g, rk_data[g], 0);
            chk("rst_index", g, rk_index[g], 0);
            chk("rst_last", g, rk_last[g], 0);
        end
        reset = 0;
        tick();

        run_case(0, K128, 0, 0);
        for (int g = 0; g < NG; g++) begin
            chk("kat128_rk1", g, cap_d[g][1], 128'ha0fafe1788542cb123a339392a6c7605);
            chk("kat128_rk10", g, cap_d[g][10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        end
        run_case(1, K192, 0, 0);
        for (int g = 0; g < NG; g++)
            chk("kat192_rk12", g, cap_d[g][12], 128'he98ba06f448c773c8ecc720401002202);
        run_case(2, K256, 0, 0);
        for (int g = 0; g < NG; g++)
            chk("kat256_rk14", g, cap_d[g][14], 128'hfe4890d1e6188d0b046df344706c631e);

        run_case(0, K128, 1, 0);
        run_case(2, K256, 1, 1);
        repeat (6)
            run_case($urandom_range(0, 2),
                     {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                     1, 1);

        // Illegal key length
        clear_mon();
        key_len = 2'd3; start = 1;
        tick();
        start = 0;
        for (int g = 0; g < NG; g++) begin
            chk("key_err_pulse", g, key_err[g], 1);
            chk("key_err_busy", g, busy[g], 0);
        end
        tick();
        for (int g = 0; g < NG; g++) chk("key_err_clear", g, key_err[g], 0);
        repeat (8) tick();
        for (int g = 0; g < NG; g++) chk("key_err_no_valid", g, vcnt[g], 0);

        // Abort an AES-128 run once rk3 has transferred
        key_len = 2'd0; key = K128; rk_ready = 1; start = 1;
        tick();
        start = 0;
        clear_mon();
        n = 0;
        while (cap_n[0] < 4 && n < 300) begin
            tick();
            n++;
        end
        chk("abort_reached_rk3", 0, cap_n[0] >= 4, 1);
        reset = 1;
        tick();
        for (int g = 0; g < NG; g++) begin
            chk("abort_valid", g, rk_valid[g], 0);
            chk("abort_busy", g, busy[g], 0);
            chk("abort_data", g, rk_data[g], 0);
            chk("abort_index", g, rk_index[g], 0);
            chk("abort_last", g, rk_last[g], 0);
            chk("abort_done", g, done[g], 0);
        end
        reset = 0;
        clear_mon();
        repeat (6) tick();
        for (int g = 0; g < NG; g++) chk("abort_quiet", g, vcnt[g], 0);
        run_case(2, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
